// File: rtl/mtm_spi_codeload_ctrl_pkg.sv
// ============================================================================
// Module : mtm_codeload_pkg
// Brief  : Shared types and constants for the SPI flash codeload sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mtm_codeload_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } codeload_state_t;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam int         CMD_BITS     = 8;
  localparam int         ADDR_BITS    = 24;
  localparam int         WORD_BITS    = 32;
  localparam int         LEN_W        = 6;

  // Flash bytes arrive first-byte-first; memory words are little-endian.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mtm_spi_codeload_ctrl_if.sv
// ============================================================================
// Module : mtm_spi_codeload_ctrl_if
// Brief  : Control, SPI pad and memory write-port bundle for the codeload block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mtm_spi_codeload_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              start;
  logic              skip;
  logic              ss;
  logic              sck;
  logic              mosi;
  logic              miso;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic              boot_done;

  modport master (
    input  start, skip, miso, mem_ready,
    output ss, sck, mosi, mem_we, mem_addr, mem_wdata, busy, boot_done
  );

  modport slave (
    output start, skip, miso, mem_ready,
    input  ss, sck, mosi, mem_we, mem_addr, mem_wdata, busy, boot_done
  );
endinterface

`default_nettype wire

// File: rtl/mtm_spi_bit_engine.sv
// ============================================================================
// Module : mtm_spi_bit_engine
// Brief  : Mode-0 SPI bit shifter: SCK divider, shift register and bit count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mtm_spi_bit_engine
  import mtm_codeload_pkg::*;
#(
  parameter int SCK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      data_i,
  input  logic             miso_i,
  output logic             sck_o,
  output logic             mosi_o,
  output logic [31:0]      rx_o,
  output logic             done_o
);
  localparam int               DIV_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

  logic             active_q;
  logic [DIV_W-1:0] div_q;
  logic             sck_q;
  logic             mosi_q;
  logic [LEN_W-1:0] bit_q;
  logic [LEN_W-1:0] len_q;
  logic [31:0]      shreg_q;

  logic [31:0]      tx_aligned;
  logic             phase_end;
  logic             last_bit;

  always_comb begin
    tx_aligned = data_i << (LEN_W'(WORD_BITS) - len_i);
    phase_end  = active_q && (div_q == DIV_LAST);
    last_bit   = (bit_q == (len_q - LEN_W'(1)));
  end

  // Asserted in the final high phase so the next transfer can be loaded on
  // the same edge that drops sck, keeping the bit stream gap-free.
  assign done_o = phase_end & sck_q & last_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      div_q    <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      bit_q    <= '0;
      len_q    <= '0;
      shreg_q  <= '0;
    end else if (go_i) begin
      active_q <= 1'b1;
      div_q    <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= tx_aligned[31];
      bit_q    <= '0;
      len_q    <= len_i;
      shreg_q  <= tx_aligned;
    end else if (active_q) begin
      if (phase_end) begin
        div_q <= '0;
        if (!sck_q) begin
          sck_q   <= 1'b1;
          shreg_q <= {shreg_q[30:0], miso_i};
        end else begin
          sck_q <= 1'b0;
          if (last_bit) begin
            active_q <= 1'b0;
            mosi_q   <= 1'b0;
          end else begin
            bit_q  <= bit_q + LEN_W'(1);
            mosi_q <= shreg_q[31];
          end
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  assign sck_o  = sck_q;
  assign mosi_o = mosi_q;
  assign rx_o   = shreg_q;

endmodule

`default_nettype wire

// File: rtl/mtm_spi_codeload_ctrl.sv
// ============================================================================
// Module : mtm_spi_codeload_ctrl
// Brief  : Boot sequencer copying a program image from SPI NOR into memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mtm_spi_codeload_ctrl
  import mtm_codeload_pkg::*;
#(
  parameter int          SCK_DIV    = 4,
  parameter int          WORD_COUNT = 2048,
  parameter int          ADDR_W     = 11,
  parameter logic [23:0] FLASH_BASE = 24'h000000
) (
  input  logic                    clk,
  input  logic                    rst,
  mtm_spi_codeload_ctrl_if.master bus
);
  localparam int               CNT_W    = $clog2(WORD_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_COUNT - 1);

  codeload_state_t   state_q, state_d;
  logic              ss_q, ss_d;
  logic              mem_we_q, mem_we_d;
  logic              boot_done_q, boot_done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              eng_go;
  logic [LEN_W-1:0]  eng_len;
  logic [31:0]       eng_data;
  logic [31:0]       eng_rx;
  logic              eng_done;
  logic              eng_sck;
  logic              eng_mosi;

  mtm_spi_bit_engine #(
    .SCK_DIV (SCK_DIV)
  ) u_engine (
    .clk    (clk),
    .rst    (rst),
    .go_i   (eng_go),
    .len_i  (eng_len),
    .data_i (eng_data),
    .miso_i (bus.miso),
    .sck_o  (eng_sck),
    .mosi_o (eng_mosi),
    .rx_o   (eng_rx),
    .done_o (eng_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ss_q        <= 1'b1;
      mem_we_q    <= 1'b0;
      boot_done_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ss_q        <= ss_d;
      mem_we_q    <= mem_we_d;
      boot_done_q <= boot_done_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    eng_go      = 1'b0;
    eng_len     = '0;
    eng_data    = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.skip) begin
            state_d = DONE;
          end else begin
            state_d  = CMD;
            eng_go   = 1'b1;
            eng_len  = LEN_W'(CMD_BITS);
            eng_data = 32'(SPI_CMD_READ);
          end
        end
      end
      CMD: begin
        if (eng_done) begin
          state_d  = ADDR;
          eng_go   = 1'b1;
          eng_len  = LEN_W'(ADDR_BITS);
          eng_data = {8'h00, FLASH_BASE};
        end
      end
      ADDR: begin
        if (eng_done) begin
          state_d = DATA;
          eng_go  = 1'b1;
          eng_len = LEN_W'(WORD_BITS);
        end
      end
      DATA: begin
        if (eng_done) begin
          state_d     = WRITE;
          mem_wdata_d = byte_swap32(eng_rx);
        end
      end
      WRITE: begin
        // Engine stays idle here, so sck/ss hold and the flash stream pauses.
        if (bus.mem_ready) begin
          cnt_d      = cnt_q + CNT_W'(1);
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end else begin
            state_d = DATA;
            eng_go  = 1'b1;
            eng_len = LEN_W'(WORD_BITS);
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ss_d        = (state_d == IDLE) || (state_d == DONE);
    mem_we_d    = (state_d == WRITE);
    boot_done_d = boot_done_q | (state_q == DONE);
  end

  assign bus.ss        = ss_q;
  assign bus.sck       = eng_sck;
  assign bus.mosi      = eng_mosi;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != IDLE) && (state_q != DONE);
  assign bus.boot_done = boot_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mtm_spi_codeload_ctrl.sv
// ============================================================================
// Module : tb_mtm_spi_codeload_ctrl
// Brief  : Directed self-checking bench with a flash model returning 00,01,02..
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mtm_spi_codeload_ctrl;
  localparam int          SCK_DIV    = 2;
  localparam int          WORD_COUNT = 4;
  localparam int          AW         = 2;
  localparam logic [23:0] BASE       = 24'h012345;
  localparam int          LAT0       = 1 + 2*SCK_DIV*(32 + 32*WORD_COUNT) + WORD_COUNT + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mtm_spi_codeload_ctrl_if #(.ADDR_W(AW)) bus();

  mtm_spi_codeload_ctrl #(
    .SCK_DIV    (SCK_DIV),
    .WORD_COUNT (WORD_COUNT),
    .ADDR_W     (AW),
    .FLASH_BASE (BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_word [0:3] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

  // Flash model and bus monitors
  logic          prev_sck  = 1'b0;
  logic          prev_mosi = 1'b0;
  int            nrise = 0, cmd_n = 0, first_rise = 0, unstable = 0, wr_n = 0;
  logic [31:0]   cmd_cap = '0, cmd_last = '0;
  logic [AW-1:0] wr_addr [0:63];
  logic [31:0]   wr_data [0:63];

  always @(negedge clk) begin
    int k;
    logic [7:0] bv;
    if (bus.mem_we && bus.mem_ready && wr_n < 64) begin
      wr_addr[wr_n] = bus.mem_addr;
      wr_data[wr_n] = bus.mem_wdata;
      wr_n++;
    end
    if (bus.ss) begin
      nrise    = 0;
      bus.miso = 1'b0;
    end else if (bus.sck && !prev_sck) begin
      if (bus.mosi !== prev_mosi) unstable++;
      if (nrise < 32) cmd_cap = {cmd_cap[30:0], bus.mosi};
      nrise++;
      if (nrise == 1) first_rise = cyc;
      if (nrise == 32) begin
        cmd_last = cmd_cap;
        cmd_n++;
      end
      if (nrise >= 32) begin
        k        = nrise - 32;
        bv       = 8'(k / 8);
        bus.miso = bv[7 - (k % 8)];
      end
    end
    prev_sck  = bus.sck;
    prev_mosi = bus.mosi;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.skip = 1'b0; bus.mem_ready = 1'b1;
    repeat (3) step();
    total++; if (bus.ss !== 1'b1) begin bad++; $display("FAIL reset_ss got=%b exp=1", bus.ss); end
    total++; if (bus.sck !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b exp=0", bus.sck); end
    total++; if (bus.mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b exp=0", bus.mosi); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", bus.mem_we); end
    total++; if (bus.mem_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bus.mem_wdata); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.boot_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.boot_done); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_skip();
    int ss_low = 0, we_hi = 0;
    bus.start = 1'b1; bus.skip = 1'b1;
    step();
    bus.start = 1'b0; bus.skip = 1'b0;
    total++; if (bus.boot_done !== 1'b0) begin bad++; $display("FAIL skip_done_t1 got=%b exp=0", bus.boot_done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL skip_busy got=%b exp=0", bus.busy); end
    step();
    total++; if (bus.boot_done !== 1'b1) begin bad++; $display("FAIL skip_done_t2 got=%b exp=1", bus.boot_done); end
    for (int i = 0; i < 6; i++) begin
      if (bus.ss !== 1'b1) ss_low++;
      if (bus.mem_we !== 1'b0) we_hi++;
      step();
    end
    total++; if (ss_low != 0) begin bad++; $display("FAIL skip_ss_low cycles got=%0d exp=0", ss_low); end
    total++; if (we_hi != 0) begin bad++; $display("FAIL skip_we cycles got=%0d exp=0", we_hi); end
    do_reset();
  endtask

  task automatic test_load_basic();
    int t, base, cn, lat;
    base = wr_n; cn = cmd_n;
    bus.mem_ready = 1'b1; bus.skip = 1'b0; bus.start = 1'b1;
    t = cyc;
    step();
    bus.start = 1'b0;
    total++; if (bus.ss !== 1'b0) begin bad++; $display("FAIL load_ss_fall got=%b exp=0", bus.ss); end
    total++; if (bus.mosi !== 1'b0) begin bad++; $display("FAIL load_mosi_bit7 got=%b exp=0", bus.mosi); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL load_busy got=%b exp=1", bus.busy); end
    for (int i = 0; i < 3000 && !bus.boot_done; i++) begin
      bus.start = (cyc == t + 60);
      step();
    end
    bus.start = 1'b0;
    lat = cyc - t;
    total++; if (bus.boot_done !== 1'b1 || lat != LAT0) begin bad++; $display("FAIL load_latency got=%0d exp=%0d", lat, LAT0); end
    total++; if (wr_n - base != WORD_COUNT) begin bad++; $display("FAIL load_write_count got=%0d exp=%0d", wr_n - base, WORD_COUNT); end
    for (int i = 0; i < WORD_COUNT && i < wr_n - base; i++) begin
      total++; if (wr_addr[base+i] !== AW'(i) || wr_data[base+i] !== exp_word[i]) begin
        bad++; $display("FAIL load_word%0d got=%0d:%h exp=%0d:%h", i, wr_addr[base+i], wr_data[base+i], i, exp_word[i]);
      end
    end
    total++; if (cmd_last !== 32'h03012345) begin bad++; $display("FAIL load_cmd_addr got=%h exp=03012345", cmd_last); end
    total++; if (cmd_n - cn != 1) begin bad++; $display("FAIL load_cmd_count got=%0d exp=1", cmd_n - cn); end
    total++; if (first_rise != t + 1 + SCK_DIV) begin bad++; $display("FAIL load_first_rise got=%0d exp=%0d", first_rise - t, 1 + SCK_DIV); end
    total++; if (unstable != 0) begin bad++; $display("FAIL load_mosi_stable got=%0d exp=0", unstable); end
    total++; if (bus.mem_addr !== '0) begin bad++; $display("FAIL load_addr_wrap got=%0d exp=0", bus.mem_addr); end
    total++; if (bus.busy !== 1'b0 || bus.ss !== 1'b1) begin bad++; $display("FAIL load_done_idle busy=%b ss=%b exp busy=0 ss=1", bus.busy, bus.ss); end
  endtask

  task automatic test_start_in_done();
    int base;
    base = wr_n;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    total++; if (bus.boot_done !== 1'b1) begin bad++; $display("FAIL done_sticky got=%b exp=1", bus.boot_done); end
    total++; if (bus.ss !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL done_restart ss=%b busy=%b exp ss=1 busy=0", bus.ss, bus.busy); end
    total++; if (wr_n != base) begin bad++; $display("FAIL done_writes got=%0d exp=0", wr_n - base); end
  endtask

  task automatic test_wait_state();
    int t, base, lat, badcyc;
    do_reset();
    base = wr_n; badcyc = 0;
    bus.mem_ready = 1'b1; bus.start = 1'b1;
    t = cyc;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 1000 && wr_n - base < 1; i++) step();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 1000 && !bus.mem_we; i++) step();
    total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL wait_we_timeout got=%b exp=1", bus.mem_we); end
    for (int i = 0; i < 10; i++) begin
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.sck, bus.ss, bus.mosi} !== {1'b1, AW'(1), exp_word[1], 3'b000}) badcyc++;
      step();
    end
    total++; if (badcyc != 0) begin bad++; $display("FAIL wait_hold bad_cycles got=%0d exp=0", badcyc); end
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3000 && !bus.boot_done; i++) step();
    lat = cyc - t;
    total++; if (bus.boot_done !== 1'b1 || lat != LAT0 + 10) begin bad++; $display("FAIL wait_latency got=%0d exp=%0d", lat, LAT0 + 10); end
    total++; if (wr_n - base != WORD_COUNT) begin bad++; $display("FAIL wait_write_count got=%0d exp=%0d", wr_n - base, WORD_COUNT); end
    for (int i = 0; i < WORD_COUNT && i < wr_n - base; i++) begin
      total++; if (wr_addr[base+i] !== AW'(i) || wr_data[base+i] !== exp_word[i]) begin
        bad++; $display("FAIL wait_word%0d got=%0d:%h exp=%0d:%h", i, wr_addr[base+i], wr_data[base+i], i, exp_word[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t, base, cn, lat;
    do_reset();
    base = wr_n;
    bus.mem_ready = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 2000 && wr_n - base < 2; i++) step();
    repeat (20) step();
    total++; if (bus.busy !== 1'b1 || bus.ss !== 1'b0) begin bad++; $display("FAIL mid_active busy=%b ss=%b exp busy=1 ss=0", bus.busy, bus.ss); end
    rst = 1'b1;
    step();
    total++; if ({bus.ss, bus.sck, bus.mosi, bus.mem_we, bus.busy, bus.boot_done} !== 6'b100000) begin
      bad++; $display("FAIL mid_reset_ctl got=%b exp=100000", {bus.ss, bus.sck, bus.mosi, bus.mem_we, bus.busy, bus.boot_done});
    end
    total++; if (bus.mem_addr !== '0 || bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL mid_reset_mem got=%0d:%h exp=0:00000000", bus.mem_addr, bus.mem_wdata); end
    rst = 1'b0;
    step();
    base = wr_n; cn = cmd_n;
    bus.start = 1'b1;
    t = cyc;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3000 && !bus.boot_done; i++) step();
    lat = cyc - t;
    total++; if (bus.boot_done !== 1'b1 || lat != LAT0) begin bad++; $display("FAIL reload_latency got=%0d exp=%0d", lat, LAT0); end
    total++; if (cmd_n - cn != 1 || cmd_last !== 32'h03012345) begin bad++; $display("FAIL reload_cmd got=%0d:%h exp=1:03012345", cmd_n - cn, cmd_last); end
    total++; if (wr_n - base != WORD_COUNT) begin bad++; $display("FAIL reload_write_count got=%0d exp=%0d", wr_n - base, WORD_COUNT); end
    else begin
      total++; if (wr_addr[base] !== '0 || wr_data[base] !== exp_word[0]) begin bad++; $display("FAIL reload_first got=%0d:%h exp=0:%h", wr_addr[base], wr_data[base], exp_word[0]); end
      total++; if (wr_data[base+3] !== exp_word[3]) begin bad++; $display("FAIL reload_last got=%h exp=%h", wr_data[base+3], exp_word[3]); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.skip = 1'b0; bus.mem_ready = 1'b1;
    test_reset();
    test_skip();
    test_load_basic();
    test_start_in_done();
    test_wait_state();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
